interleave_seq: RTL and testbench

INTERLEAVE_SEQ -- requirements
Module: interleave_seq

---
 rtl/interleave_seq.sv | 150 +++++++++++++++
 tb/tb_interleave_seq.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/interleave_seq.sv
// Sequencer that toggles the input of an external inverter chain and checks that
// every stage settles in order and within a cycle budget, counting completed toggles.
module interleave_seq #(
  parameter int N_STAGES = 5,
  parameter int TIMEOUT  = 15,
  parameter int CNT_W    = 8,
  localparam int FS_W    = (N_STAGES > 1) ? $clog2(N_STAGES) : 1,
  localparam int TM_W    = ($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [CNT_W-1:0]    num_toggles,
  output logic                drive,
  input  logic [N_STAGES-1:0] taps,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [FS_W-1:0]     fail_stage,
  output logic [CNT_W-1:0]    toggle_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_WAIT, S_DONE} state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic                r_drive;
  logic                r_error;
  logic [FS_W-1:0]     r_fail_stage;
  logic [CNT_W-1:0]    r_toggle_cnt;
  logic [CNT_W-1:0]    r_tgt;
  logic [TM_W-1:0]     r_timer;
  logic [N_STAGES-1:0] r_settled;
  logic [N_STAGES-1:0] r_sync1;
  logic [N_STAGES-1:0] r_sync2;

  logic [N_STAGES-1:0] w_expected;
  logic [N_STAGES-1:0] w_match;
  logic [N_STAGES-1:0] w_order_err;
  logic [N_STAGES-1:0] w_settled_nx;
  logic [FS_W-1:0]     w_order_idx;
  logic [FS_W-1:0]     w_unset_idx;
  logic [CNT_W-1:0]    w_cnt_inc;
  logic                w_all_set;
  logic                w_timeout;

  // Even-indexed stages see an odd number of inversions, so they expect ~drive.
  genvar gi;
  generate
    for (gi = 0; gi < N_STAGES; gi++) begin : g_stage
      if ((gi % 2) == 0) begin : g_inv
        assign w_expected[gi] = ~r_drive;
      end else begin : g_buf
        assign w_expected[gi] = r_drive;
      end
      assign w_match[gi] = (r_sync2[gi] == w_expected[gi]);
      if (gi == 0) begin : g_first
        assign w_order_err[gi] = 1'b0;
      end else begin : g_rest
        assign w_order_err[gi] = w_match[gi] & ~r_settled[gi-1];
      end
    end
  endgenerate

  assign w_settled_nx = r_settled | w_match;
  assign w_all_set    = &w_settled_nx;
  assign w_timeout    = (r_timer == TM_W'(TIMEOUT)) && !w_all_set;
  assign w_cnt_inc    = r_toggle_cnt + 1'b1;

  always_comb begin
    w_order_idx = '0;
    w_unset_idx = '0;
    for (int i = N_STAGES - 1; i >= 0; i--) begin
      if (w_order_err[i])   w_order_idx = FS_W'(i);
      if (!w_settled_nx[i]) w_unset_idx = FS_W'(i);
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = (num_toggles == '0) ? S_DONE : S_DRIVE;
      S_DRIVE: w_next_state = S_WAIT;
      S_WAIT: begin
        if (|w_order_err)   w_next_state = S_DONE;
        else if (w_all_set) w_next_state = (w_cnt_inc == r_tgt) ? S_DONE : S_DRIVE;
        else if (w_timeout) w_next_state = S_DONE;
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_drive      <= 1'b0;
      r_error      <= 1'b0;
      r_fail_stage <= '0;
      r_toggle_cnt <= '0;
      r_tgt        <= '0;
      r_timer      <= '0;
      r_settled    <= '0;
      r_sync1      <= '0;
      r_sync2      <= '0;
    end else begin
      r_state <= w_next_state;
      r_sync1 <= taps;
      r_sync2 <= r_sync1;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_tgt        <= num_toggles;
            r_toggle_cnt <= '0;
            r_error      <= 1'b0;
            r_fail_stage <= '0;
          end
        end
        S_DRIVE: begin
          r_drive   <= ~r_drive;
          r_timer   <= '0;
          r_settled <= '0;
        end
        S_WAIT: begin
          r_settled <= w_settled_nx;
          if (r_timer != TM_W'(TIMEOUT)) r_timer <= r_timer + 1'b1;
          // Ordering takes precedence over timeout when both fire together.
          if (|w_order_err) begin
            r_error      <= 1'b1;
            r_fail_stage <= w_order_idx;
          end else if (w_all_set) begin
            r_toggle_cnt <= w_cnt_inc;
          end else if (w_timeout) begin
            r_error      <= 1'b1;
            r_fail_stage <= w_unset_idx;
          end
        end
        default: ;
      endcase
    end
  end

  assign drive      = r_drive;
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign error      = r_error;
  assign fail_stage = r_fail_stage;
  assign toggle_cnt = r_toggle_cnt;

endmodule

// File: tb/tb_interleave_seq.sv
// Bench for interleave_seq: a delay-line chain model drives taps, and an
// arrival-time model predicts count, error, failing stage and done latency per run.
module tb_interleave_seq;

  localparam int NS  = 5;
  localparam int TO  = 15;
  localparam int HL  = 24;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] num_toggles;
  logic       drive;
  logic [4:0] taps;
  logic       busy;
  logic       done;
  logic       error;
  logic [2:0] fail_stage;
  logic [7:0] toggle_cnt;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          dly [NS];
  logic [4:0]  stuck_en;
  logic [4:0]  stuck_val;
  logic [HL-1:0] hist;
  bit          m_drive;

  interleave_seq #(.N_STAGES(NS), .TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .num_toggles(num_toggles),
    .drive(drive), .taps(taps), .busy(busy), .done(done), .error(error),
    .fail_stage(fail_stage), .toggle_cnt(toggle_cnt)
  );

  always #5 clk = ~clk;

  // Chain model: stage i shows the drive value from dly[i] cycles ago, inverted on even stages.
  always @(posedge clk) begin
    if (reset) hist <= '0;
    else       hist <= {hist[HL-2:0], drive};
  end

  always_comb begin
    taps = '0;
    for (int i = 0; i < NS; i++)
      taps[i] = stuck_en[i] ? stuck_val[i] : (hist[dly[i]-1] ^ ((i % 2) == 0));
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Arrival model: stage i first matches at WAIT cycle d[i] (chain delay + 2 sync cycles).
  // It may match only once stage i-1 matched in an earlier cycle.
  task automatic model_run(input int n, output int cnt, output bit err, output int fs,
                           output int cyc, inout bit drv);
    int  d [NS];
    int  ord, unset;
    bit  all, stop;
    cnt = 0; err = 0; fs = 0; cyc = 1; stop = (n == 0);
    while (!stop) begin
      drv = ~drv;
      cyc += 1;
      for (int i = 0; i < NS; i++) begin
        if (stuck_en[i]) d[i] = (stuck_val[i] == (drv ^ ((i % 2) == 0))) ? 0 : 1000;
        else             d[i] = dly[i] + 2;
      end
      for (int t = 0; t <= TO; t++) begin
        cyc += 1;
        ord = -1; unset = -1; all = 1;
        for (int i = 1; i < NS; i++)
          if (ord < 0 && t >= d[i] && d[i-1] >= t) ord = i;
        for (int i = 0; i < NS; i++)
          if (d[i] > t) begin all = 0; if (unset < 0) unset = i; end
        if (ord >= 0) begin err = 1; fs = ord; stop = 1; break; end
        if (all) begin cnt++; if (cnt == n) stop = 1; break; end
        if (t == TO) begin err = 1; fs = unset; stop = 1; break; end
      end
    end
  endtask

  // Called at a negedge; returns at a negedge after the chain has flushed.
  task automatic do_run(input int n, input int extra_at);
    int e_cnt, e_fs, e_cyc, cyc;
    bit e_err, e_drv;
    e_drv = m_drive;
    model_run(n, e_cnt, e_err, e_fs, e_cyc, e_drv);
    start = 1'b1; num_toggles = 8'(n);
    @(negedge clk); start = 1'b0; num_toggles = 8'($urandom);
    cyc = 1;
    while (done !== 1'b1 && cyc < 2000) begin
      if (cyc == extra_at) begin
        check("busy_mid_run", busy, 1);
        start = 1'b1; num_toggles = 8'd1;
      end
      @(negedge clk); start = 1'b0; cyc++;
    end
    check("done_cycle", cyc, e_cyc);
    check("toggle_cnt", toggle_cnt, e_cnt);
    check("error", error, e_err);
    check("fail_stage", fail_stage, e_fs);
    check("drive", drive, e_drv);
    check("busy_in_done", busy, 1);
    m_drive = e_drv;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("done_width", done, 0);
    check("start_in_done_ignored", busy, 0);
    $display("[TB] run n=%0d cnt=%0d err=%0d fs=%0d cycles=%0d", n, toggle_cnt, error, fail_stage, cyc);
    repeat (30) @(negedge clk);
    check("hold_cnt", toggle_cnt, e_cnt);
    check("hold_error", error, e_err);
  endtask

  initial begin
    bit saw_done;
    clk = 1'b0; reset = 1'b1; start = 1'b0; num_toggles = '0;
    stuck_en = '0; stuck_val = '0; m_drive = 1'b0;
    for (int i = 0; i < NS; i++) dly[i] = i + 1;
    repeat (3) @(negedge clk);
    check("rst_drive", drive, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_fail_stage", fail_stage, 0);
    check("rst_toggle_cnt", toggle_cnt, 0);
    reset = 1'b0;

    do_run(4, -1);                       // nominal, start on first cycle after reset
    do_run(1, -1);                       // leaves drive high
    stuck_en = 5'b00100; stuck_val = '0; // stage 2 stuck low
    repeat (30) @(negedge clk);
    do_run(3, -1);
    stuck_en = '0;
    dly[0] = 1; dly[1] = 2; dly[2] = 5; dly[3] = 3; dly[4] = 6;
    repeat (30) @(negedge clk);
    do_run(2, -1);                       // stage 3 arrives before stage 2
    for (int i = 0; i < NS; i++) dly[i] = i + 1;
    repeat (30) @(negedge clk);
    do_run(0, -1);                       // zero toggles
    do_run(5, 6);                        // extra start while busy

    // Reset in the middle of a run.
    start = 1'b1; num_toggles = 8'd6;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    check("busy_before_abort", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_drive", drive, 0);
    check("abort_busy", busy, 0);
    check("abort_error", error, 0);
    check("abort_toggle_cnt", toggle_cnt, 0);
    check("abort_fail_stage", fail_stage, 0);
    reset = 1'b0; m_drive = 1'b0;
    saw_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    check("abort_no_done", saw_done, 0);
    $display("[TB] reset abort: drive=%0d busy=%0d cnt=%0d", drive, busy, toggle_cnt);

    // Randomised runs.
    for (int r = 0; r < 14; r++) begin
      if ($urandom_range(0, 9) < 7) begin
        dly[0] = $urandom_range(1, 3);
        for (int i = 1; i < NS; i++) dly[i] = dly[i-1] + $urandom_range(1, 3);
      end else begin
        for (int i = 0; i < NS; i++) dly[i] = $urandom_range(1, 16);
      end
      stuck_en = '0; stuck_val = 5'($urandom);
      if ($urandom_range(0, 9) < 2) stuck_en[$urandom_range(0, NS-1)] = 1'b1;
      repeat (30) @(negedge clk);
      do_run($urandom_range(0, 6), ($urandom_range(0, 1) == 1) ? $urandom_range(2, 10) : -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
